gray_counter_param: RTL and testbench

Parametrised up/down Gray-code counter with synchronous load, enable, terminal-count and wrap indication.
- Successor to the fixed 4-bit Gray counter. Generalises width and adds direction control, load and status flags.
- Used as a pointer or position source where only one output bit may change per count, e.g. clock-domain-crossing pointers and encoder emulation.
- Binary and Gray values are both registered and always mutually consistent; the Gray output has no one-cycle lag.

---
 rtl/gray_counter_param.sv | 61 ++++++
 tb/tb_gray_counter_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
// rtl/gray_counter_param.sv - parametrised up/down Gray counter with load, tc and wrap flags
// Optional build macro GRAY_CNT_SATURATE_EN: hold at the terminal value instead of wrapping.
module gray_counter_param #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc,
  output logic             wrap
);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  assign tc = up_dn ? (&bin_q) : ~(|bin_q);

  always_comb begin
    bin_step  = up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);
    bin_next  = bin_step;
    wrap_next = tc;
`ifdef GRAY_CNT_SATURATE_EN
    // At the terminal value the step is suppressed, so no wrap can occur.
    if (tc) begin
      bin_next = bin_q;
    end
    wrap_next = 1'b0;
`endif
  end

  // Gray is derived from the same next-binary value so both registers stay consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= RESET_VAL;
      gray_q <= to_gray(RESET_VAL);
      wrap   <= 1'b0;
    end else if (load) begin
      bin_q  <= load_val;
      gray_q <= to_gray(load_val);
      wrap   <= 1'b0;
    end else if (en) begin
      bin_q  <= bin_next;
      gray_q <= to_gray(bin_next);
      wrap   <= wrap_next;
    end else begin
      wrap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// tb/tb_gray_counter_param.sv - directed self-checking bench for gray_counter_param
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] bin_q, gray_q;
  logic       tc, wrap;

  logic       load8 = 1'b0;
  logic [7:0] load_val8 = 8'h00;
  logic [7:0] bin_q8, gray_q8;
  logic       tc8, wrap8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bin_q(bin_q), .gray_q(gray_q), .tc(tc), .wrap(wrap)
  );

  gray_counter_param #(.WIDTH(8), .RESET_VAL(8'hF0)) dut8 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load8),
    .load_val(load_val8), .bin_q(bin_q8), .gray_q(gray_q8), .tc(tc8), .wrap(wrap8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0;
    step(); step();
    n_cmp++;
    if ({bin_q, gray_q, wrap, tc} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset4: bin=%h gray=%h wrap=%b tc=%b expected bin=0 gray=0 wrap=0 tc=1",
               bin_q, gray_q, wrap, tc);
    end
    n_cmp++;
    if ({bin_q8, gray_q8, wrap8} !== {8'hF0, 8'h88, 1'b0}) begin
      n_bad++;
      $display("FAIL reset8: bin=%h gray=%h wrap=%b expected bin=f0 gray=88 wrap=0",
               bin_q8, gray_q8, wrap8);
    end
    reset = 1'b0;
  endtask

  task automatic test_up_sweep();
    logic [3:0] gtab [16];
    logic [3:0] prev_gray;
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k < 16; k++) begin
      prev_gray = gray_q;
      step();
      n_cmp++;
      if ({bin_q, gray_q, wrap} !== {k[3:0], gtab[k], 1'b0}) begin
        n_bad++;
        $display("FAIL up_sweep[%0d]: bin=%h gray=%h wrap=%b expected bin=%h gray=%h wrap=0",
                 k, bin_q, gray_q, wrap, k[3:0], gtab[k]);
      end
      n_cmp++;
      if ($countones(prev_gray ^ gray_q) != 1) begin
        n_bad++;
        $display("FAIL one_bit[%0d]: gray %h -> %h expected exactly one bit change", k, prev_gray, gray_q);
      end
      n_cmp++;
      if (tc !== (k == 15)) begin
        n_bad++;
        $display("FAIL tc_up[%0d]: tc=%b expected %b", k, tc, (k == 15));
      end
    end
    prev_gray = gray_q;
    step();
`ifdef GRAY_CNT_SATURATE_EN
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'hF, 4'h8, 1'b0}) begin
      n_bad++;
      $display("FAIL up_sat: bin=%h gray=%h wrap=%b expected bin=f gray=8 wrap=0", bin_q, gray_q, wrap);
    end
`else
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'h0, 4'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL up_wrap: bin=%h gray=%h wrap=%b expected bin=0 gray=0 wrap=1", bin_q, gray_q, wrap);
    end
    n_cmp++;
    if ($countones(prev_gray ^ gray_q) != 1) begin
      n_bad++;
      $display("FAIL one_bit_wrap: gray %h -> %h expected exactly one bit change", prev_gray, gray_q);
    end
`endif
    en = 1'b0;
    step();
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_one_cycle: wrap=%b expected 0", wrap);
    end
  endtask

  task automatic test_load_down();
    load = 1'b1; load_val = 4'hA; en = 1'b1; up_dn = 1'b0;
    step();
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'hA, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL load: bin=%h gray=%h wrap=%b expected bin=a gray=f wrap=0", bin_q, gray_q, wrap);
    end
    load = 1'b0;
    step();
    n_cmp++;
    if ({bin_q, gray_q} !== {4'h9, 4'hD}) begin
      n_bad++;
      $display("FAIL down: bin=%h gray=%h expected bin=9 gray=d", bin_q, gray_q);
    end
    up_dn = 1'b1;
    step();
    n_cmp++;
    if ({bin_q, gray_q} !== {4'hA, 4'hF}) begin
      n_bad++;
      $display("FAIL dir_change: bin=%h gray=%h expected bin=a gray=f", bin_q, gray_q);
    end
    en = 1'b0;
    step(); step();
    n_cmp++;
    if ({bin_q, gray_q, wrap, tc} !== {4'hA, 4'hF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL hold: bin=%h gray=%h wrap=%b tc=%b expected bin=a gray=f wrap=0 tc=0",
               bin_q, gray_q, wrap, tc);
    end
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_val = 4'h0; en = 1'b0; up_dn = 1'b0;
    step();
    load = 1'b0;
    n_cmp++;
    if (tc !== 1'b1) begin
      n_bad++;
      $display("FAIL tc_down: tc=%b expected 1 (en low)", tc);
    end
    en = 1'b1;
    step();
    en = 1'b0;
`ifdef GRAY_CNT_SATURATE_EN
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL down_sat: bin=%h gray=%h wrap=%b expected bin=0 gray=0 wrap=0", bin_q, gray_q, wrap);
    end
    en = 1'b1; up_dn = 1'b1;
    step();
    en = 1'b0;
    n_cmp++;
    if ({bin_q, gray_q} !== {4'h1, 4'h1}) begin
      n_bad++;
      $display("FAIL sat_resume: bin=%h gray=%h expected bin=1 gray=1", bin_q, gray_q);
    end
`else
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'hF, 4'h8, 1'b1}) begin
      n_bad++;
      $display("FAIL down_wrap: bin=%h gray=%h wrap=%b expected bin=f gray=8 wrap=1", bin_q, gray_q, wrap);
    end
`endif
    step();
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL down_wrap_pulse: wrap=%b expected 0", wrap);
    end
  endtask

  task automatic test_priority();
    reset = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'h5;
    step();
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL prio_reset: bin=%h gray=%h wrap=%b expected bin=0 gray=0 wrap=0", bin_q, gray_q, wrap);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({bin_q, gray_q} !== {4'h5, 4'h7}) begin
      n_bad++;
      $display("FAIL prio_load: bin=%h gray=%h expected bin=5 gray=7", bin_q, gray_q);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; load_val = 4'h6; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; en = 1'b0;
    n_cmp++;
    if ({bin_q, gray_q, wrap} !== {4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: bin=%h gray=%h wrap=%b expected bin=0 gray=0 wrap=0", bin_q, gray_q, wrap);
    end
    n_cmp++;
    if ({bin_q8, gray_q8, wrap8} !== {8'hF0, 8'h88, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid8: bin=%h gray=%h wrap=%b expected bin=f0 gray=88 wrap=0",
               bin_q8, gray_q8, wrap8);
    end
    // Reset on a would-be wrap step must leave wrap low.
    load = 1'b1; load_val = 4'hF;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; en = 1'b0;
    n_cmp++;
    if ({bin_q, wrap} !== {4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_wrap: bin=%h wrap=%b expected bin=0 wrap=0", bin_q, wrap);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_up_sweep();
    test_load_down();
    test_down_wrap();
    test_priority();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
